// File: rtl/pio_bank_pkg.sv
// Shared constants for the double-buffered parameter bank.
// Register offsets are relative to the first address after the shadow words.
package pio_bank_pkg;
  localparam int CTRL_OFS    = 0;
  localparam int STATUS_OFS  = 1;
  localparam int COMMITS_OFS = 2;
  localparam int COMMIT_BIT  = 0;
  localparam int AUTO_BIT    = 1;
  localparam int OVERRUN_W   = 8;
  localparam int COMMITS_W   = 16;
endpackage

// File: rtl/pio_commit_ctrl.sv
// Commit handshake: pending flag, overrun and commit counters,
// and the registered update pulse that follows each transfer.
module pio_commit_ctrl
  import pio_bank_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic                 fabric_ready,
  input  logic                 ovr_clr,
  output logic                 pending,
  output logic                 xfer,
  output logic [OVERRUN_W-1:0] overrun,
  output logic [COMMITS_W-1:0] commits,
  output logic                 out_update
);

  logic ovr_sat;

  assign xfer    = pending & fabric_ready;
  assign ovr_sat = &overrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      overrun    <= '0;
      commits    <= '0;
      out_update <= 1'b0;
    end else begin
      out_update <= xfer;
      if (xfer)
        commits <= commits + 1'b1;
      if (req)
        pending <= 1'b1;
      else if (xfer)
        pending <= 1'b0;
      // a request landing on a transfer edge still counts as overrun
      if (ovr_clr)
        overrun <= '0;
      else if (req && pending && !ovr_sat)
        overrun <= overrun + 1'b1;
    end
  end

endmodule

// File: rtl/pio_param_bank.sv
// Avalon-MM parameter bank: shadow words written by the HPS are copied
// to the active set atomically when the fabric signals it is safe.
module pio_param_bank
  import pio_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 27,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic                     fabric_ready,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     out_update,
  output logic                     pending
);

  localparam logic [ADDR_W-1:0] NCH_A  = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(NUM_CH + CTRL_OFS);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(NUM_CH + STATUS_OFS);
  localparam logic [ADDR_W-1:0] CMT_A  = ADDR_W'(NUM_CH + COMMITS_OFS);

  logic [DATA_W-1:0]    shadow [NUM_CH];
  logic [DATA_W-1:0]    active [NUM_CH];
  logic                 wr;
  logic                 wr_sh;
  logic                 wr_ctrl;
  logic                 wr_stat;
  logic                 sel_ctrl;
  logic                 sel_stat;
  logic                 sel_cmt;
  logic                 auto_mode;
  logic                 req;
  logic                 xfer;
  logic [OVERRUN_W-1:0] overrun;
  logic [COMMITS_W-1:0] commits;
  logic                 unused_wd;

  assign sel_ctrl  = (address == CTRL_A);
  assign sel_stat  = (address == STAT_A);
  assign sel_cmt   = (address == CMT_A);
  assign wr        = chipselect & ~write_n;
  assign wr_sh     = wr & (address < NCH_A);
  assign wr_ctrl   = wr & sel_ctrl;
  assign wr_stat   = wr & sel_stat;
  assign req       = (wr_ctrl & writedata[COMMIT_BIT])
                   | (wr_sh & auto_mode);
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++)
        shadow[k] <= '0;
    end else if (wr_sh) begin
      for (int k = 0; k < NUM_CH; k++)
        if (address == ADDR_W'(k))
          shadow[k] <= writedata[DATA_W-1:0];
    end
  end

  // actives take the pre-write shadows on the transfer edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++)
        active[k] <= '0;
    end else if (xfer) begin
      for (int k = 0; k < NUM_CH; k++)
        active[k] <= shadow[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      auto_mode <= 1'b0;
    else if (wr_ctrl)
      auto_mode <= writedata[AUTO_BIT];
  end

  pio_commit_ctrl u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .fabric_ready (fabric_ready),
    .ovr_clr      (wr_stat),
    .pending      (pending),
    .xfer         (xfer),
    .overrun      (overrun),
    .commits      (commits),
    .out_update   (out_update)
  );

  always_comb begin
    readdata = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (address == ADDR_W'(k))
        readdata = 32'(shadow[k]);
    unique case (1'b1)
      sel_ctrl: readdata[AUTO_BIT] = auto_mode;
      sel_stat: readdata = {16'b0, overrun, 7'b0, pending};
      sel_cmt:  readdata = 32'(commits);
      default:  ;
    endcase
  end

  always_comb begin
    out_port = '0;
    for (int k = 0; k < NUM_CH; k++)
      out_port[k*DATA_W +: DATA_W] = active[k];
  end

endmodule
